// File: rtl/cpu_checker_arbiter.sv
// cpu_checker_arbiter: shares one cpu_checker between two trace-character sources one whole
// record at a time, routes each verdict back to its source and times out stalled records.
module cpu_checker_arbiter #(
   parameter int unsigned STALL_MAX = 16,
   parameter logic [7:0]  IDLE_CHAR = 8'h00
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [7:0]  src0_char,
   input  logic        src0_valid,
   output logic        src0_ready,
   input  logic [7:0]  src1_char,
   input  logic        src1_valid,
   output logic        src1_ready,
   output logic [7:0]  chk_char,
   input  logic [1:0]  chk_format_type,
   input  logic [3:0]  chk_error_code,
   output logic        res_valid,
   output logic        res_src,
   output logic [1:0]  res_format,
   output logic [3:0]  res_error,
   output logic        res_abort,
   output logic [15:0] pass_cnt0,
   output logic [15:0] pass_cnt1,
   output logic [7:0]  abort_cnt,
   output logic        owner,
   output logic        busy
);
   localparam logic [7:0] TERM = 8'h23;
   typedef enum logic {IDLE, BUSY} state_t;
   state_t      state_q, state_d;
   logic        owner_q, owner_d, prio_q, prio_d;
   logic [7:0]  timer_q, timer_d, chk_q, chk_d, abort_q, abort_d;
   logic [2:0]  tag1_q, tag1_d, tag2_q;
   logic [15:0] pass0_q, pass0_d, pass1_q, pass1_d;
   logic        res_valid_q, res_src_q, res_abort_q;
   logic [1:0]  res_format_q;
   logic [3:0]  res_error_q;
   logic        own_valid, hs, done, timeout;
   logic [7:0]  own_char;

   always_comb begin
      own_valid = owner_q ? src1_valid : src0_valid;
      own_char  = owner_q ? src1_char : src0_char;
      hs        = state_q == BUSY && own_valid;
      done      = hs && own_char == TERM;
      timeout   = state_q == BUSY && !own_valid && timer_q == 8'(STALL_MAX - 1);
   end

   always_ff @(posedge clk or posedge reset)
      if (reset) state_q <= IDLE;
      else state_q <= state_d;

   always_comb begin
      state_d = state_q == IDLE ? (src0_valid || src1_valid ? BUSY : IDLE)
                                : (done || timeout ? IDLE : BUSY);
      owner_d = state_q == IDLE && (src0_valid || src1_valid)
                ? (src0_valid && src1_valid ? prio_q : src1_valid) : owner_q;
   end

   always_comb begin
      src0_ready = state_q == BUSY && !owner_q;
      src1_ready = state_q == BUSY && owner_q;
   end

   // Tag layout {valid, src, abort}; stage 2 lines up with the checker's verdict.
   always_comb begin
      prio_d  = done || timeout ? !owner_q : prio_q;
      timer_d = state_q == IDLE || hs ? 8'd0 : timer_q + 8'd1;
      chk_d   = timeout ? TERM : hs ? own_char : IDLE_CHAR;
      tag1_d  = {done || timeout, owner_q, timeout};
      abort_d = timeout && abort_q != 8'hff ? abort_q + 8'd1 : abort_q;
      pass0_d = tag2_q[2] && !tag2_q[1] && !tag2_q[0] && chk_format_type != 2'd0 ? pass0_q + 16'd1 : pass0_q;
      pass1_d = tag2_q[2] && tag2_q[1] && !tag2_q[0] && chk_format_type != 2'd0 ? pass1_q + 16'd1 : pass1_q;
   end

   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         owner_q      <= 1'b0;
         prio_q       <= 1'b0;
         timer_q      <= 8'd0;
         chk_q        <= IDLE_CHAR;
         abort_q      <= 8'd0;
         tag1_q       <= 3'd0;
         tag2_q       <= 3'd0;
         pass0_q      <= 16'd0;
         pass1_q      <= 16'd0;
         res_valid_q  <= 1'b0;
         res_src_q    <= 1'b0;
         res_format_q <= 2'd0;
         res_error_q  <= 4'd0;
         res_abort_q  <= 1'b0;
      end else begin
         owner_q     <= owner_d;
         prio_q      <= prio_d;
         timer_q     <= timer_d;
         chk_q       <= chk_d;
         abort_q     <= abort_d;
         tag1_q      <= tag1_d;
         tag2_q      <= tag1_q;
         pass0_q     <= pass0_d;
         pass1_q     <= pass1_d;
         res_valid_q <= tag2_q[2];
         if (tag2_q[2]) begin
            res_src_q    <= tag2_q[1];
            res_abort_q  <= tag2_q[0];
            res_format_q <= chk_format_type;
            res_error_q  <= chk_error_code;
         end
      end

   assign chk_char   = chk_q;
   assign res_valid  = res_valid_q;
   assign res_src    = res_src_q;
   assign res_format = res_format_q;
   assign res_error  = res_error_q;
   assign res_abort  = res_abort_q;
   assign pass_cnt0  = pass0_q;
   assign pass_cnt1  = pass1_q;
   assign abort_cnt  = abort_q;
   assign owner      = owner_q;
   assign busy       = state_q == BUSY;
endmodule

// File: tb/tb_cpu_checker_arbiter.sv
// tb_cpu_checker_arbiter: random record traffic from two sources, a small checker stand-in,
// and a record-level reference model of verdicts, attribution, fairness and counters.
module tb_cpu_checker_arbiter;
   localparam int STALL_MAX = 16;
   typedef struct packed {logic [1:0] fmt; logic [3:0] err; logic abort;} exp_t;
   logic        clk = 1'b0, reset = 1'b0;
   logic [7:0]  src0_char, src1_char, chk_char, abort_cnt;
   logic        src0_valid, src1_valid, src0_ready, src1_ready;
   logic [1:0]  chk_format_type, res_format;
   logic [3:0]  chk_error_code, res_error;
   logic        res_valid, res_src, res_abort, owner, busy;
   logic [15:0] pass_cnt0, pass_cnt1;
   logic        stub_star;
   logic [7:0]  stub_last, stub_len;
   int          checks = 0, failures = 0, cyc = 0, gmax = 0, ac = 0;
   string       rs[2][$];
   bit          stq[2][$];
   exp_t        eq[2][$];
   int          hq[$], rlog[$];
   string       cur[2];
   bit          cur_st[2], act[2], hs[2];
   int          pos[2], gap[2], wcnt[2], last_hs[2];
   logic [15:0] pc[2];

   cpu_checker_arbiter #(.STALL_MAX(STALL_MAX), .IDLE_CHAR(8'h00)) dut (
      .clk(clk), .reset(reset),
      .src0_char(src0_char), .src0_valid(src0_valid), .src0_ready(src0_ready),
      .src1_char(src1_char), .src1_valid(src1_valid), .src1_ready(src1_ready),
      .chk_char(chk_char), .chk_format_type(chk_format_type), .chk_error_code(chk_error_code),
      .res_valid(res_valid), .res_src(res_src), .res_format(res_format), .res_error(res_error),
      .res_abort(res_abort), .pass_cnt0(pass_cnt0), .pass_cnt1(pass_cnt1), .abort_cnt(abort_cnt),
      .owner(owner), .busy(busy)
   );

   always #5 clk = ~clk;

   // Checker stand-in: verdict after '#' depends on the record's last char and any '*'.
   always @(posedge clk or posedge reset)
      if (reset) begin
         chk_format_type <= 2'd0; chk_error_code <= 4'd0;
         stub_star <= 1'b0; stub_last <= 8'h00; stub_len <= 8'd0;
      end else if (chk_char == "^") begin
         stub_star <= 1'b0; stub_last <= chk_char; stub_len <= 8'd1;
      end else if (chk_char == "#") begin
         chk_format_type <= stub_last == " " ? 2'd0 : stub_star ? 2'd2 : 2'd1;
         chk_error_code  <= stub_last == " " ? stub_len[3:0] : 4'd0;
      end else if (chk_char != 8'h00) begin
         stub_star <= stub_star | (chk_char == "*");
         stub_last <= chk_char; stub_len <= stub_len + 8'd1;
      end

   function automatic exp_t verdict(string p, bit ab);
      exp_t e;
      bit star = 0;
      for (int i = 0; i < p.len(); i++) if (p[i] == "*") star = 1;
      e.fmt   = p[p.len()-1] == " " ? 2'd0 : star ? 2'd2 : 2'd1;
      e.err   = e.fmt == 2'd0 ? 4'(p.len()) : 4'd0;
      e.abort = ab;
      return e;
   endfunction

   function automatic string rand_rec(int k);
      if (k == 0) return $sformatf("^%03d@%08h: $%02d <= %08h#", $urandom_range(0, 999), $urandom(), $urandom_range(0, 31), $urandom());
      if (k == 1) return $sformatf("^%03d@%08h: *%08h <= %08h#", $urandom_range(0, 999), $urandom(), $urandom(), $urandom());
      return $sformatf("^%03d@%08h: *%08h <= #", $urandom_range(0, 999), $urandom(), $urandom());
   endfunction

   task automatic send(int s, string str, bit st);
      rs[s].push_back(str);
      stq[s].push_back(st);
      eq[s].push_back(verdict(st ? str : str.substr(0, str.len() - 2), st));
   endtask

   task automatic clear_tb();
      for (int s = 0; s < 2; s++) begin
         rs[s].delete(); stq[s].delete(); eq[s].delete();
         act[s] = 0; hs[s] = 0; pos[s] = 0; gap[s] = 0; wcnt[s] = 0; pc[s] = 16'd0;
      end
      hq.delete(); rlog.delete(); ac = 0;
      src0_valid = 0; src1_valid = 0; src0_char = 8'h00; src1_char = 8'h00;
   endtask

   task automatic drive(int s);
      logic v;
      logic [7:0] c;
      if (hs[s]) begin
         pos[s]++; last_hs[s] = cyc;
         if (pos[s] == cur[s].len() && !cur_st[s]) act[s] = 0;
         gap[s] = gmax > 0 ? $urandom_range(0, gmax) : 0;
      end
      if (act[s] && cur_st[s] && pos[s] == cur[s].len()) begin
         wcnt[s]++;
         if (wcnt[s] > STALL_MAX + 1) act[s] = 0;
      end
      v = 0; c = 8'h00;
      if (gap[s] > 0) gap[s]--;
      else begin
         if (!act[s] && rs[s].size() > 0) begin
            cur[s] = rs[s].pop_front(); cur_st[s] = stq[s].pop_front();
            act[s] = 1; pos[s] = 0; wcnt[s] = 0;
         end
         if (act[s] && pos[s] < cur[s].len()) begin v = 1; c = cur[s][pos[s]]; end
      end
      if (s == 0) begin src0_valid = v; src0_char = v ? c : 8'($urandom()); end
      else begin src1_valid = v; src1_char = v ? c : 8'($urandom()); end
      hs[s] = v && (s == 0 ? src0_ready : src1_ready);
   endtask

   task automatic step();
      exp_t e;
      @(posedge clk); #1; cyc++;
      if (chk_char == "#") hq.push_back(cyc);
      checks++;
      if (src0_ready !== (busy && !owner) || src1_ready !== (busy && owner)) begin
         failures++;
         $display("FAIL ready_rule cyc=%0d got ready=%b%b required for busy=%b owner=%b", cyc, src1_ready, src0_ready, busy, owner);
      end
      if (res_valid) begin
         rlog.push_back(int'(res_src));
         checks++;
         if (eq[res_src].size() == 0) begin
            failures++;
            $display("FAIL res_unexpected cyc=%0d got src=%0d required no result", cyc, res_src);
         end else begin
            e = eq[res_src].pop_front();
            if (!e.abort && e.fmt != 2'd0) pc[res_src] = pc[res_src] + 16'd1;
            if (e.abort && ac < 255) ac++;
            if ({res_format, res_error, res_abort} !== e) begin
               failures++;
               $display("FAIL res_fields src=%0d got fmt=%0d err=%0d abort=%0d required fmt=%0d err=%0d abort=%0d",
                        res_src, res_format, res_error, res_abort, e.fmt, e.err, e.abort);
            end
            checks++;
            if (pass_cnt0 !== pc[0] || pass_cnt1 !== pc[1] || abort_cnt !== 8'(ac)) begin
               failures++;
               $display("FAIL counters got %0d/%0d/%0d required %0d/%0d/%0d", pass_cnt0, pass_cnt1, abort_cnt, pc[0], pc[1], ac);
            end
            checks++;
            if (hq.size() == 0 || cyc != hq[0] + 2) begin
               failures++;
               $display("FAIL res_latency got cyc=%0d required terminator cyc+2 (queued %0d)", cyc, hq.size());
            end
            if (hq.size() > 0) void'(hq.pop_front());
         end
      end
      drive(0);
      drive(1);
   endtask

   task automatic run(int maxc);
      int n = 0;
      while ((rs[0].size() + rs[1].size() + eq[0].size() + eq[1].size() > 0 || act[0] || act[1]) && n < maxc) begin
         step(); n++;
      end
      checks++;
      if (n >= maxc) begin
         failures++;
         $display("FAIL run_timeout got %0d pending results after %0d cycles required 0", eq[0].size() + eq[1].size(), n);
      end
   endtask

   task automatic release_reset();
      repeat (2) @(posedge clk);
      #3 reset = 1'b0;
   endtask

   task automatic test_reset();
      clear_tb();
      #1 reset = 1'b1;
      #1 checks++;
      if ({chk_char, res_valid, res_src, res_format, res_error, res_abort, pass_cnt0, pass_cnt1,
           abort_cnt, owner, busy, src0_ready, src1_ready} !== 61'd0) begin
         failures++;
         $display("FAIL reset_values got %h %b %0d %0d %0d required all zero", chk_char, busy, pass_cnt0, pass_cnt1, abort_cnt);
      end
      release_reset();
   endtask

   task automatic test_both_valid();
      rlog.delete();
      send(0, "^242@000030f4: $31 <= 12345678#", 0);
      send(1, "^242@000030f4: $31 <= 12345678#", 0);
      run(300);
      checks++;
      if (rlog.size() != 2 || rlog[0] != 0 || rlog[1] != 1) begin
         failures++;
         $display("FAIL both_valid_order got %0d results first=%0d required 2 results src 0 then 1", rlog.size(), rlog.size() ? rlog[0] : -1);
      end
      checks++;
      if (pass_cnt0 !== 16'd1 || pass_cnt1 !== 16'd1) begin
         failures++;
         $display("FAIL both_valid_pass got %0d/%0d required 1/1", pass_cnt0, pass_cnt1);
      end
   endtask

   task automatic test_round_robin();
      rlog.delete();
      repeat (2) begin
         send(0, "^338@00003130: *00000088 <= ffffb528#", 0);
         send(1, "^338@00003130: *00000088 <= ffffb528#", 0);
      end
      run(600);
      checks++;
      if (rlog.size() != 4 || rlog[0] != 0) begin
         failures++;
         $display("FAIL rr_start got %0d results first=%0d required 4 first=0", rlog.size(), rlog.size() ? rlog[0] : -1);
      end else
         for (int i = 1; i < 4; i++) begin
            checks++;
            if (rlog[i] == rlog[i-1]) begin
               failures++;
               $display("FAIL rr_alternate got src=%0d twice at result %0d required alternation", rlog[i], i);
            end
         end
   endtask

   task automatic test_error_record();
      rlog.delete();
      send(0, "^338@00003130: *00000088 <= #", 0);
      run(300);
      checks++;
      if (rlog.size() != 1 || res_format !== 2'd0 || res_error !== 4'd12 || abort_cnt !== 8'd0) begin
         failures++;
         $display("FAIL error_record got n=%0d fmt=%0d err=%0d aborts=%0d required 1 0 12 0", rlog.size(), res_format, res_error, abort_cnt);
      end
   endtask

   task automatic test_stall();
      int n = 0;
      rlog.delete();
      send(0, "^242@0000", 1);
      while (!(busy && owner == 1'b0) && n < 20) begin step(); n++; end
      send(1, "^242@000030f4: $31 <= 12345678#", 0);
      n = 0;
      while (chk_char !== "#" && n < 100) begin step(); n++; end
      checks++;
      if (chk_char !== "#" || cyc - last_hs[0] != STALL_MAX) begin
         failures++;
         $display("FAIL stall_timeout got chk=%h after %0d idle cycles required 23 after %0d", chk_char, cyc - last_hs[0], STALL_MAX);
      end
      run(300);
      checks++;
      if (rlog.size() != 2 || rlog[0] != 0 || rlog[1] != 1 || abort_cnt !== 8'd1) begin
         failures++;
         $display("FAIL stall_then_src1 got n=%0d first=%0d aborts=%0d required 2 0 1", rlog.size(), rlog.size() ? rlog[0] : -1, abort_cnt);
      end
   endtask

   task automatic test_random();
      string s;
      int k;
      gmax = 3;
      for (int i = 0; i < 40; i++) begin
         s = rand_rec($urandom_range(0, 2));
         k = $urandom_range(0, 3);
         if (k == 0) send(i % 2, s.substr(0, $urandom_range(0, s.len() - 3)), 1);
         else send($urandom_range(0, 1), s, 0);
      end
      run(20000);
      gmax = 0;
   endtask

   task automatic test_reset_mid();
      int n = 0, seen = 0;
      send(0, "^242@000030f4: $31 <= 12345678#", 0);
      while (pos[0] < 7 && n < 50) begin step(); n++; end
      #2 reset = 1'b1;
      #1 checks++;
      if ({chk_char, res_valid, res_src, res_format, res_error, res_abort, pass_cnt0, pass_cnt1,
           abort_cnt, owner, busy, src0_ready, src1_ready} !== 61'd0) begin
         failures++;
         $display("FAIL reset_async got %h %b %0d %0d %0d required all zero", chk_char, busy, pass_cnt0, pass_cnt1, abort_cnt);
      end
      clear_tb();
      release_reset();
      repeat (6) begin step(); seen += int'(res_valid); end
      checks++;
      if (seen != 0) begin
         failures++;
         $display("FAIL reset_drop got %0d results required 0", seen);
      end
      send(1, "^242@000030f4: $31 <= 12345678#", 0);
      send(0, "^242@000030f4: $31 <= 12345678#", 0);
      run(300);
      checks++;
      if (rlog.size() != 2 || rlog[0] != 0) begin
         failures++;
         $display("FAIL reset_first_grant got n=%0d first=%0d required 2 0", rlog.size(), rlog.size() ? rlog[0] : -1);
      end
   endtask

   task automatic test_abort_saturate();
      for (int i = 0; i < 256; i++) send(0, "^", 1);
      run(256 * 25);
      checks++;
      if (abort_cnt !== 8'd255) begin
         failures++;
         $display("FAIL abort_saturate got %0d required 255", abort_cnt);
      end
   endtask

   initial begin
      test_reset();
      test_both_valid();
      test_round_robin();
      test_error_record();
      test_stall();
      test_random();
      test_reset_mid();
      test_abort_saturate();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
